// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, SKIP condition codes, FSM states.
// Opcode 8 (SUB) is only decoded when ACC_CPU_SUB_EN is defined.
package acc_cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;
  localparam logic [3:0] OP_SKIP  = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;
  localparam logic [3:0] OP_SUB   = 4'h8;

  localparam logic [2:0] SKIP_NEG  = 3'b000;
  localparam logic [2:0] SKIP_ZERO = 3'b010;
  localparam logic [2:0] SKIP_POS  = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DECODE,
    MEM,
    HALTED
  } state_e;

  typedef enum logic [1:0] {
    ALU_NONE,
    ALU_LOAD,
    ALU_ADD,
    ALU_SUB
  } alu_op_e;

endpackage

// File: rtl/acc_cpu_decode.sv
// Combinational opcode decoder for the accumulator CPU.
// Build option ACC_CPU_SUB_EN: when defined, opcode 8 decodes as SUB; otherwise it is illegal.
module acc_cpu_decode
  import acc_cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem_read,
  output logic       is_store,
  output alu_op_e    alu_op,
  output logic       illegal
);

  always_comb begin
    is_mem_read = 1'b0;
    is_store    = 1'b0;
    alu_op      = ALU_NONE;
    illegal     = 1'b0;
    case (opcode)
      OP_ADD: begin
        is_mem_read = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_LOAD: begin
        is_mem_read = 1'b1;
        alu_op      = ALU_LOAD;
      end
      OP_STORE: is_store = 1'b1;
      OP_HALT, OP_CLEAR, OP_SKIP, OP_JUMP, OP_ADDI: ;
`ifdef ACC_CPU_SUB_EN
      OP_SUB: begin
        is_mem_read = 1'b1;
        alu_op      = ALU_SUB;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU: FETCH/LATCH/DECODE/MEM FSM against a single-port synchronous RAM.
// Build option ACC_CPU_SUB_EN enables the SUB opcode (see acc_cpu_decode).
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 28,
  parameter int          IMM_WIDTH  = 8,
  parameter int unsigned RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  retire,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] acc
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

  state_e                       state;
  logic [DATA_WIDTH-1:0]        ir;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic                         illegal_q;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  dec_mem_read;
  logic                  dec_store;
  alu_op_e               dec_alu_op;
  logic                  dec_illegal;
  logic                  unused_ir;

  function automatic logic signed [DATA_WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] imm);
    return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  endfunction

  function automatic logic skip_taken(input logic [2:0] cond,
                                      input logic signed [DATA_WIDTH-1:0] a);
    case (cond)
      SKIP_ZERO: return (a == '0);
      SKIP_NEG:  return a[DATA_WIDTH-1];
      SKIP_POS:  return !a[DATA_WIDTH-1] && (a != '0);
      default:   return 1'b0;
    endcase
  endfunction

  assign opcode    = ir[DATA_WIDTH-1 -: 4];
  assign operand   = ir[ADDR_WIDTH-1:0];
  assign unused_ir = ^ir;

  acc_cpu_decode u_decode (
    .opcode      (opcode),
    .is_mem_read (dec_mem_read),
    .is_store    (dec_store),
    .alu_op      (dec_alu_op),
    .illegal     (dec_illegal)
  );

  assign acc     = acc_q;
  assign halted  = (state == HALTED);
  assign illegal = illegal_q;

  // Memory controls and retire are a pure function of the registered state and IR
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_addr = pc;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
      end
      DECODE: begin
        if (dec_mem_read) begin
          mem_addr = operand;
          mem_cs   = 1'b1;
          mem_oe   = 1'b1;
        end else if (dec_store) begin
          mem_addr  = operand;
          mem_wdata = acc_q;
          mem_cs    = 1'b1;
          mem_we    = 1'b1;
        end
        retire = !dec_mem_read && !dec_illegal;
      end
      MEM:     retire = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC_A;
      acc_q     <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc        <= RESET_PC_A;
            acc_q     <= '0;
            illegal_q <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;
          state <= DECODE;
        end
        DECODE: begin
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state     <= HALTED;
          end else if (dec_mem_read) begin
            state <= MEM;
          end else begin
            state <= FETCH;
            case (opcode)
              OP_HALT:  state <= HALTED;
              OP_CLEAR: acc_q <= '0;
              OP_SKIP:  if (skip_taken(ir[2:0], acc_q)) pc <= pc + 1'b1;
              OP_JUMP:  pc <= operand;
              OP_ADDI:  acc_q <= acc_q + sext_imm(ir[IMM_WIDTH-1:0]);
              default:  ;
            endcase
          end
        end
        MEM: begin
          case (dec_alu_op)
            ALU_LOAD: acc_q <= mem_rdata;
            ALU_ADD:  acc_q <= acc_q + mem_rdata;
            ALU_SUB:  acc_q <= acc_q - mem_rdata;
            default:  ;
          endcase
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: RAM model, ISA-level reference model feeding a scoreboard.
// Opcode 8 expectations follow ACC_CPU_SUB_EN.
module tb_acc_cpu_core;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam logic [AW-1:0] RPC = 28'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_cs, mem_we, mem_oe;
  logic          retire, halted, illegal;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;

  logic [DW-1:0] mem  [0:4095];
  logic [DW-1:0] mmem [0:4095];

  typedef struct packed {
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wp;

  acc_cpu_core #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (28),
    .IMM_WIDTH  (8),
    .RESET_PC   ('h100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .pc        (pc),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, 4K words aliased over the address space
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[mem_addr[11:0]] = mem_wdata;
    if (mem_cs && mem_oe && !mem_we) mem_rdata <= mem[mem_addr[11:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] opd);
    return {op, opd};
  endfunction

  task automatic put(input logic [31:0] w);
    mem[wp & 'hFFF] = w;
    wp++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_ctl"}, {mem_cs, mem_we, mem_oe}, 3'b000);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_flags"}, {retire, halted, illegal}, 3'b000);
  endtask

  // Instruction-level reference: one scoreboard entry per retiring instruction
  task automatic model_run(output logic ill);
    logic [AW-1:0] mpc;
    logic [DW-1:0] ac, w;
    logic [3:0]    op;
    logic [AW-1:0] opd;
    int            lat;
    bit            stop;
    exp_t          e;
    mmem = mem;
    mpc = RPC; ac = '0; ill = 1'b0; stop = 1'b0;
    for (int k = 0; k < 1000 && !stop; k++) begin
      w = mmem[mpc[11:0]];
      mpc = mpc + 1'b1;
      op = w[31:28];
      opd = w[27:0];
      lat = 3;
      case (op)
        4'h0: begin ac = ac + mmem[opd[11:0]]; lat = 4; end
        4'h1: stop = 1'b1;
        4'h2: begin ac = mmem[opd[11:0]]; lat = 4; end
        4'h3: mmem[opd[11:0]] = ac;
        4'h4: ac = '0;
        4'h5: if ((w[2:0] == 3'b010 && ac == 0) || (w[2:0] == 3'b000 && ac[31]) ||
                  (w[2:0] == 3'b100 && !ac[31] && ac != 0)) mpc = mpc + 1'b1;
        4'h6: mpc = opd;
        4'h7: ac = ac + {{24{w[7]}}, w[7:0]};
`ifdef ACC_CPU_SUB_EN
        4'h8: begin ac = ac - mmem[opd[11:0]]; lat = 4; end
`endif
        default: begin ill = 1'b1; stop = 1'b1; end
      endcase
      if (!ill) begin
        e.acc = ac; e.pc = mpc; e.lat = lat;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic run_prog(input string name, input int budget);
    logic exp_ill;
    exp_t e;
    int   cyc, mark, nret, nexp;
    bit   pending, done;
    sbq.delete();
    model_run(exp_ill);
    nexp = sbq.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_start_clr"}, {halted, illegal}, 2'b00);
    check({name, "_fetch_ctl"}, {mem_cs, mem_oe, mem_we, mem_addr}, {3'b110, RPC});
    cyc = 0; mark = 0; nret = 0; pending = 1'b0; done = 1'b0;
    while (!done) begin
      if (pending) begin
        check({name, "_acc"}, acc, e.acc);
        check({name, "_pc"}, pc, e.pc);
        pending = 1'b0;
      end
      if (retire) begin
        nret++;
        if (sbq.size() == 0) check({name, "_extra_retire"}, nret, nexp);
        else begin
          e = sbq.pop_front();
          check({name, "_lat"}, cyc - mark + 1, e.lat);
          pending = 1'b1;
        end
        mark = cyc + 1;
      end
      if (halted && !pending) done = 1'b1;
      else if (cyc >= budget) begin
        check({name, "_timeout"}, cyc, budget + 1);
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_retire_cnt"}, nret, nexp);
    check({name, "_halted"}, halted, 1'b1);
    check({name, "_illegal"}, illegal, exp_ill);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // Fibonacci: a=M[111], b=M[112], t=M[113], count=M[114]
    mem['h111] = 0; mem['h112] = 1; mem['h113] = 0; mem['h114] = 10;
    wp = 'h100;
    put(ins(2, 'h111)); put(ins(0, 'h112)); put(ins(3, 'h113));
    put(ins(2, 'h112)); put(ins(3, 'h111));
    put(ins(2, 'h113)); put(ins(3, 'h112));
    put(ins(2, 'h114)); put(ins(7, 'hFF)); put(ins(3, 'h114));
    put(ins(5, 3'b010)); put(ins(6, 'h100)); put(ins(1, 0));
    run_prog("fib", 3000);
    check("fib_m113", mem['h113], 89);
    check("fib_m111", mem['h111], 55);
    check("fib_m114", mem['h114], 0);

    // STORE then LOAD back after CLEAR
    mem['h300] = 32'hDEADBEEF;
    wp = 'h100;
    put(ins(2, 'h300)); put(ins(3, 'h200)); put(ins(4, 0));
    put(ins(2, 'h200)); put(ins(1, 0));
    run_prog("stld", 200);
    check("stld_acc", acc, 32'hDEADBEEF);
    check("stld_m200", mem['h200], 32'hDEADBEEF);

    // SKIP conditions on zero, negative, positive and the most negative value
    mem['h301] = 32'h80000000;
    wp = 'h100;
    put(ins(4, 0)); put(ins(5, 2)); put(ins(7, 'h10));
    put(ins(5, 0)); put(ins(7, 'hFF)); put(ins(5, 0)); put(ins(7, 'h10));
    put(ins(5, 2)); put(ins(5, 4)); put(ins(7, 2)); put(ins(5, 4)); put(ins(7, 'h10));
    put(ins(5, 0)); put(ins(5, 6)); put(ins(2, 'h301)); put(ins(5, 4));
    put(ins(5, 0)); put(ins(7, 'h10)); put(ins(1, 0));
    run_prog("skip", 300);
    check("skip_acc", acc, 32'h80000000);

    // ADD wrap and negative immediate
    mem['h302] = 32'hFFFFFFFF; mem['h303] = 2;
    wp = 'h100;
    put(ins(2, 'h302)); put(ins(0, 'h303)); put(ins(7, 4)); put(ins(7, 'hFF)); put(ins(1, 0));
    run_prog("arith", 200);
    check("arith_acc", acc, 4);

    // Opcode 8
    wp = 'h100;
    put(ins(4, 0)); put(ins(7, 7)); put(ins(8, 'h303)); put(ins(1, 0));
    run_prog("op8", 200);
`ifdef ACC_CPU_SUB_EN
    check("op8_acc", acc, 5);
`else
    check("op8_acc", acc, 7);
`endif

    // Always-illegal opcode
    wp = 'h100;
    put(ins(7, 3)); put(ins(4'hB, 0)); put(ins(1, 0));
    run_prog("op11", 200);
    check("op11_acc", acc, 3);

    // JUMP to the top of the address space, fall through wraps PC to 0
    wp = 'h100;
    put(ins(6, 28'hFFFFFFF));
    mem['hFFF] = ins(7, 3);
    mem[0] = ins(1, 0);
    run_prog("wrap", 200);
    check("wrap_pc", pc, 1);
    check("wrap_acc", acc, 3);

    // Asynchronous reset asserted during the MEM cycle of a LOAD
    wp = 'h100;
    put(ins(2, 'h300)); put(ins(1, 0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_dec_ctl", {mem_cs, mem_oe, mem_we, mem_addr}, {3'b110, 28'h300});
    @(negedge clk);
    check("rst_mem_retire", retire, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    check("rst_hold_acc", acc, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised multicycle accumulator CPU core: fetches, decodes and executes the team's 4-bit-opcode accumulator ISA against a single-port synchronous RAM (`single_port_sync_ram_large` interface: addr/data/cs/we/oe). It replaces the testbench-embedded fetch/execute loop with a synthesisable FSM, with configurable widths, a start/halt handshake, correct signed SKIP and a registered HALT state. It sits between the top-level and the RAM; the test bench only preloads memory and pulses `start`.

## Interface
- `DATA_WIDTH`, 32, word and accumulator width; must be ≥ `ADDR_WIDTH`+4
- `ADDR_WIDTH`, 28, memory address / operand field width
- `IMM_WIDTH`, 8, ADDI immediate width (operand bits [IMM_WIDTH-1:0], sign-extended)
- `RESET_PC`, 'h100, program entry address
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; begins execution from `RESET_PC`
- `mem_addr`  out  ADDR_WIDTH  RAM address
- `mem_wdata`  out  DATA_WIDTH  RAM write data
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after the read request
- `mem_cs`, `mem_we`, `mem_oe`  out  1 each  RAM chip select / write enable / output enable
- `retire`  out  1  one-cycle pulse per completed instruction
- `halted`  out  1  high while in HALTED
- `illegal`  out  1  sticky; set on an undefined opcode
- `pc`, `acc`  out  ADDR_WIDTH / DATA_WIDTH  architectural state, for observation

## Operation
- Format: opcode = bits [DATA_WIDTH-1:DATA_WIDTH-4]; operand = bits [ADDR_WIDTH-1:0].
- Opcodes: 0 ADD (AC+=M[op]), 1 HALT, 2 LOAD, 3 STORE (M[op]=AC), 4 CLEAR, 5 SKIP, 6 JUMP (PC=op), 7 ADDI (AC+=sext(imm)), 8 SUB when enabled.
- SKIP: operand[2:0]=010 → skip if AC==0; 000 → if AC<0 (signed); 100 → if AC>0 (signed); other codes are no-ops. Skip = PC+1.
- FSM: IDLE → FETCH (addr=PC, cs=oe=1) → LATCH (IR←rdata, PC←PC+1) → DECODE → MEM (ADD/SUB/LOAD only) → FETCH.
- DECODE: ADD/SUB/LOAD issue a read of operand and go to MEM; STORE drives addr=op, wdata=AC, cs=we=1, oe=0 and retires; CLEAR/SKIP/JUMP/ADDI update and retire; HALT → HALTED (retires); undefined opcode → set `illegal`, → HALTED.
- MEM: AC ← rdata, AC+rdata or AC−rdata; retire.
- Arithmetic wraps modulo 2^DATA_WIDTH; PC increments/skips wrap modulo 2^ADDR_WIDTH.
- `start` in IDLE or HALTED: PC←RESET_PC, AC←0, `halted`/`illegal` cleared, → FETCH. `start` ignored in all other states.
- Memory controls are Moore outputs of the state register; cs=we=oe=0 in IDLE, HALTED, LATCH.

## Timing
- Reset (async, any state including mid-STORE): state IDLE, PC=RESET_PC, AC=0, IR=0, all mem controls 0, `mem_addr`=0, `mem_wdata`=0, `retire`=`halted`=`illegal`=0.
- Latency from entering FETCH to `retire`: 3 cycles for CLEAR/SKIP/JUMP/ADDI/STORE/HALT; 4 cycles for ADD/SUB/LOAD.
- First FETCH is the cycle after `start` is sampled.
- `retire` high in the last cycle of the instruction; next FETCH immediately follows.
- STORE write commits at the clock edge ending DECODE; a LOAD of the same address in the next instruction returns the new value.

## Configuration
- `ACC_CPU_SUB_EN`: defined → opcode 8 is SUB (4-cycle, AC−M[op]). Undefined → opcode 8 is undefined (sets `illegal`, halts). Opcodes 9–15 always illegal.

## Structure
- Package `acc_cpu_pkg`: opcode localparams, SKIP condition codes, FSM state enum (IDLE, FETCH, LATCH, DECODE, MEM, HALTED).
- Sub-module `acc_cpu_decode`: combinational opcode → control (is_mem_read, is_store, alu_op, illegal); FSM and datapath stay in the core.

## Test plan
- Fibonacci program at 'h100 (data 0,1,0,10 at 'h111–'h114), `start` → halts with M['h113] = 55-series terms; `halted`=1, `retire` count matches instruction trace.
- STORE 'h200 with AC='hDEADBEEF then LOAD 'h200 after CLEAR → AC='hDEADBEEF.
- SKIP: AC=0/−1/+1 with codes 010/000/100 → PC advances by 2 only when condition holds; AC='h80000000 with 100 → no skip.
- ADDI imm 'hFF on AC=5 → AC=4; ADD wrap 'hFFFFFFFF+2 → 1.
- Opcode 8 → SUB result with `ACC_CPU_SUB_EN`, else `illegal`=1, `halted`=1.
- `rst_n` low during MEM of LOAD → outputs at reset values immediately; JUMP to 'hFFFFFFF then fall-through → PC wraps to 0.
